// File: rtl/axis_tx_pkg.sv
// axis_tx_pkg: shared FSM state, keep-mask and byte-counting payload helpers for the AXIS frame generator/checker
package axis_tx_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int MAX_KEEP = 128;
  function automatic logic [MAX_KEEP-1:0] keep_mask(input int r, input int n);
    return {MAX_KEEP{1'b1}} >> (MAX_KEEP - (r == 0 ? n : r));
  endfunction
  function automatic logic [MAX_KEEP*8-1:0] pattern_beat(input logic [7:0] seed, input int beat_idx, input int n);
    logic [MAX_KEEP*8-1:0] d;
    d = '0;
    for (int i = 0; i < MAX_KEEP; i++) d[i*8+:8] = seed + 8'(beat_idx * n) + 8'(i);
    return d;
  endfunction
endpackage

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: command (len/seed/sideband) in, one registered AXIS frame of seed-counting bytes out; busy/zero_len_err/frames_sent status
module axis_frame_tx
  import axis_tx_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int AXIS_TDEST_WIDTH = 4,
  parameter int AXIS_TID_WIDTH = 4,
  parameter int AXIS_TUSER_WIDTH = 4,
  parameter int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        m_axis_clk,
  input  logic                        m_axis_rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  input  logic [7:0]                  cmd_seed,
  input  logic [AXIS_TDEST_WIDTH-1:0] cmd_tdest,
  input  logic [AXIS_TID_WIDTH-1:0]   cmd_tid,
  input  logic [AXIS_TUSER_WIDTH-1:0] cmd_tuser,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [AXIS_TKEEP_WIDTH-1:0] m_axis_tstrb,
  output logic [AXIS_TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [AXIS_TID_WIDTH-1:0]   m_axis_tid,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic                        zero_len_err,
  output logic [CNT_WIDTH-1:0]        frames_sent
);
  localparam int KW = AXIS_TKEEP_WIDTH;
  localparam int DW = AXIS_TDATA_WIDTH;
  state_t state;
  logic [LEN_WIDTH-1:0] beat, last_beat, rem, nb, lb, rr;
  logic [7:0] seed;
  logic hs, acc, ld, nl;
  logic [KW-1:0] nk;
  logic [DW-1:0] pat, nd;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign cmd_ready = state == IDLE || (hs && m_axis_tlast);
  assign acc = cmd_valid && cmd_ready;
  assign ld = acc && cmd_len != '0;
  assign busy = m_axis_tvalid || state == SEND;
  assign m_axis_tstrb = m_axis_tkeep;
  // next beat is either beat 0 of a freshly accepted command or the successor of the current one
  always_comb begin
    nb = ld ? '0 : beat + 1'b1;
    lb = ld ? LEN_WIDTH'(({1'b0, cmd_len} + (LEN_WIDTH+1)'(KW - 1)) / (LEN_WIDTH+1)'(KW) - 1'b1) : last_beat;
    rr = ld ? cmd_len % LEN_WIDTH'(KW) : rem;
    nl = nb == lb;
    nk = nl ? KW'(keep_mask(int'(rr), KW)) : '1;
    pat = DW'(pattern_beat(ld ? cmd_seed : seed, int'(nb), KW));
    nd = '0;
    for (int i = 0; i < KW; i++) nd[i*8+:8] = nk[i] ? pat[i*8+:8] : 8'h00;
  end
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state <= IDLE;
      beat <= '0;
      last_beat <= '0;
      rem <= '0;
      seed <= '0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tdest <= '0;
      m_axis_tid <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
      zero_len_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      zero_len_err <= acc && cmd_len == '0;
      if (hs && m_axis_tlast) frames_sent <= frames_sent + 1'b1;
      if (ld) begin
        state <= SEND;
        beat <= nb;
        last_beat <= lb;
        rem <= rr;
        seed <= cmd_seed;
        m_axis_tdest <= cmd_tdest;
        m_axis_tid <= cmd_tid;
        m_axis_tuser <= cmd_tuser;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= nd;
        m_axis_tkeep <= nk;
        m_axis_tlast <= nl;
      end else if (hs && m_axis_tlast) begin
        state <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata <= '0;
        m_axis_tkeep <= '0;
        m_axis_tlast <= 1'b0;
      end else if (hs) begin
        beat <= nb;
        m_axis_tdata <= nd;
        m_axis_tkeep <= nk;
        m_axis_tlast <= nl;
      end
    end
  end
endmodule

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: directed self-checking bench for axis_frame_tx
module tb_axis_frame_tx;
  logic clk, rst, cmd_valid, cmd_ready, tlast, tvalid, tready, busy, zero_len_err;
  logic [15:0] cmd_len;
  logic [7:0] cmd_seed, tkeep, tstrb;
  logic [3:0] cmd_tdest, cmd_tid, cmd_tuser, tdest, tid, tuser;
  logic [63:0] tdata;
  logic [31:0] frames_sent;
  int n_chk = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [63:0] d; logic [7:0] k; logic [7:0] s; logic l; logic [3:0] dst; logic [3:0] id; logic [3:0] usr; int c;} beat_t;
  beat_t log_q[$];
  logic stall;
  logic [63:0] pd;
  logic [7:0] pk;
  logic pl;
  axis_frame_tx dut (
    .m_axis_clk(clk), .m_axis_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .cmd_tdest(cmd_tdest), .cmd_tid(cmd_tid), .cmd_tuser(cmd_tuser),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tstrb(tstrb),
    .m_axis_tdest(tdest), .m_axis_tid(tid), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .busy(busy), .zero_len_err(zero_len_err), .frames_sent(frames_sent)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // beats are logged and held-beat stability is checked on the falling edge
  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, pd);
        chk("hold_keep", tkeep, pk);
        chk("hold_last", tlast, pl);
      end
      if (tvalid && tready) log_q.push_back('{tdata, tkeep, tstrb, tlast, tdest, tid, tuser, cyc});
      stall = tvalid && !tready;
      pd = tdata;
      pk = tkeep;
      pl = tlast;
    end
  end
  task automatic send_cmd(input int len, input logic [7:0] sd, input logic [3:0] dst);
    int n = 0;
    cmd_len = 16'(len);
    cmd_seed = sd;
    cmd_tdest = dst;
    cmd_tid = dst + 4'd1;
    cmd_tuser = ~dst;
    cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_accept_timeout", n < 500, 1);
    @(posedge clk);
    #2 cmd_valid = 0;
  endtask
  task automatic wait_idle(input bit rnd);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      if (rnd) tready = 1'($urandom_range(0, 1));
      n++;
    end while (busy && n < 2000);
    chk("idle_timeout", n < 2000, 1);
    tready = 1;
  endtask
  task automatic chk_frame(input int base, input int len, input logic [7:0] sd, input logic [3:0] dst);
    int nbeats = (len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      logic [63:0] d = '0;
      logic [7:0] k = '0;
      for (int i = 0; i < 8; i++) begin
        int idx = b * 8 + i;
        if (idx < len) begin
          d[i*8+:8] = sd + 8'(idx);
          k[i] = 1;
        end
      end
      chk($sformatf("len%0d_b%0d_data", len, b), log_q[base+b].d, d);
      chk($sformatf("len%0d_b%0d_keep", len, b), log_q[base+b].k, k);
      chk($sformatf("len%0d_b%0d_strb", len, b), log_q[base+b].s, k);
      chk($sformatf("len%0d_b%0d_last", len, b), log_q[base+b].l, b == nbeats - 1);
      chk($sformatf("len%0d_b%0d_side", len, b), {log_q[base+b].dst, log_q[base+b].id, log_q[base+b].usr}, {dst, dst + 4'd1, ~dst});
    end
  endtask
  initial begin
    rst = 1; cmd_valid = 0; cmd_len = 0; cmd_seed = 0; cmd_tdest = 0; cmd_tid = 0; cmd_tuser = 0; tready = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_zle", zero_len_err, 0);
    chk("rst_tdata_tkeep_tlast", {tdata, tkeep, tlast}, 0);
    rst = 0;
    tready = 1;
    // len 20, seed 0x10: three beats, last partial
    log_q.delete();
    send_cmd(20, 8'h10, 4'h3);
    wait_idle(0);
    chk("t1_beats", log_q.size(), 3);
    chk_frame(0, 20, 8'h10, 4'h3);
    chk("t1_b0_lit", log_q[0].d, 64'h1716151413121110);
    chk("t1_b2_lit", log_q[2].d, 64'h0000000023222120);
    chk("t1_k2_lit", log_q[2].k, 8'h0F);
    chk("t1_frames", frames_sent, 1);
    // len 16, seed 0xFC: byte wrap, full last beat
    log_q.delete();
    send_cmd(16, 8'hFC, 4'h5);
    wait_idle(0);
    chk("t2_beats", log_q.size(), 2);
    chk_frame(0, 16, 8'hFC, 4'h5);
    chk("t2_b0_lit", log_q[0].d, 64'h03020100FFFEFDFC);
    chk("t2_byte4", log_q[0].d[39:32], 8'h00);
    chk("t2_k1_lit", log_q[1].k, 8'hFF);
    chk("t2_frames", frames_sent, 2);
    // len 8 then len 9 back to back
    log_q.delete();
    send_cmd(8, 8'h00, 4'h1);
    send_cmd(9, 8'h40, 4'h2);
    wait_idle(0);
    chk("t3_beats", log_q.size(), 3);
    chk_frame(0, 8, 8'h00, 4'h1);
    chk_frame(1, 9, 8'h40, 4'h2);
    chk("t3_gap01", log_q[1].c - log_q[0].c, 1);
    chk("t3_gap12", log_q[2].c - log_q[1].c, 1);
    chk("t3_k2_lit", log_q[2].k, 8'h01);
    chk("t3_d2_lit", log_q[2].d, 64'h48);
    chk("t3_frames", frames_sent, 4);
    // len 100 with random backpressure
    log_q.delete();
    send_cmd(100, 8'h33, 4'h7);
    wait_idle(1);
    chk("t4_beats", log_q.size(), 13);
    chk_frame(0, 100, 8'h33, 4'h7);
    chk("t4_k12_lit", log_q[12].k, 8'h0F);
    chk("t4_frames", frames_sent, 5);
    // zero-length command
    log_q.delete();
    send_cmd(0, 8'h00, 4'h0);
    chk("t5_zle_hi", zero_len_err, 1);
    chk("t5_tvalid0", tvalid, 0);
    chk("t5_busy0", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #2;
    chk("t5_zle_lo", zero_len_err, 0);
    chk("t5_tvalid1", tvalid, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("t5_no_beats", log_q.size(), 0);
    chk("t5_frames", frames_sent, 5);
    // reset on beat 1 of a len 40 frame
    send_cmd(40, 8'h00, 4'h2);
    @(posedge clk);
    #2;
    chk("t6_pre_valid", tvalid, 1);
    rst = 1;
    #1;
    chk("t6_async_tvalid", tvalid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_tlast", tlast, 0);
    @(posedge clk);
    #2 rst = 0;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_frames", frames_sent, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_no_recovery", tvalid, 0);
    log_q.delete();
    send_cmd(8, 8'h80, 4'h4);
    wait_idle(0);
    chk("t6_beats", log_q.size(), 1);
    chk_frame(0, 8, 8'h80, 4'h4);
    chk("t6_d0_lit", log_q[0].d, 64'h8786858483828180);
    chk("t6_frames_after", frames_sent, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
